// File: rtl/pos_shifter_pkg.sv
// Shared types and sizing helper for the one-hot position shifter.
package pos_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_e;

  // Counter must hold values up to max(TIMER, REPEAT) - 1; REPEAT only counts when auto-repeat is built.
  function automatic int cnt_width(input int timer_cycles, input int repeat_cycles,
                                   input bit repeat_en);
    int m;
    m = timer_cycles;
    if (repeat_en && repeat_cycles > m) m = repeat_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/shift_hold_counter.sv
// Qualify/repeat counter for pos_shifter. Clear and enable together load 1
// (clear, then count the current cycle), which is how a fresh press starts.
module shift_hold_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= en_i ? CW'(1) : '0;
    else if (en_i)  cnt_q <= cnt_q + CW'(1);
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pos_shifter.sv
// One-hot position shifter driven by left/right button levels, with press
// qualification and saturate/rotate ends. Optional hold-to-repeat: SHIFTER_AUTOREPEAT_EN.
module pos_shifter
  import pos_shifter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int TIMER     = 1,
  parameter int WRAP      = 0,
  parameter int RESET_POS = 0,
  parameter int REPEAT    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_left,
  input  logic                     shift_right,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     at_msb,
  output logic                     at_lsb,
  output logic                     shifted
);

`ifdef SHIFTER_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  localparam int                CW         = cnt_width(TIMER, REPEAT, AR_EN);
  localparam int                PW         = $clog2(WIDTH);
  localparam logic [CW-1:0]     TIMER_LAST = CW'(TIMER - 1);
  localparam logic [WIDTH-1:0]  RESET_OUT  = WIDTH'(1) << RESET_POS;
`ifdef SHIFTER_AUTOREPEAT_EN
  localparam logic [CW-1:0]     REPEAT_LAST = CW'(REPEAT - 1);
`endif

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  dir_e              req;
  dir_e              shift_dir;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              shifted_q, shifted_d;
  logic              start;
  logic              cnt_clr;
  logic              cnt_en;
  logic [CW-1:0]     cnt;

  shift_hold_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt   (cnt)
  );

  // Both buttons high decodes as no request.
  always_comb begin
    req = DIR_NONE;
    if (shift_left && !shift_right)      req = DIR_L;
    else if (shift_right && !shift_left) req = DIR_R;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NONE;
      out_q     <= RESET_OUT;
      shifted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      shifted_q <= shifted_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    shift_dir = DIR_NONE;
    start     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != DIR_NONE) start   = 1'b1;
        else                 cnt_clr = 1'b1;
      end
      ST_ARM: begin
        if (req == DIR_NONE) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (req != dir_q) begin
          start = 1'b1;
        end else if (cnt == TIMER_LAST) begin
          shift_dir = dir_q;
          state_d   = ST_FIRED;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FIRED: begin
        if (req == DIR_NONE) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (req != dir_q) begin
          start = 1'b1;
        end else begin
`ifdef SHIFTER_AUTOREPEAT_EN
          if (cnt == REPEAT_LAST) begin
            shift_dir = dir_q;
            cnt_clr   = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // A new or changed direction starts qualification from scratch.
    if (start) begin
      dir_d   = req;
      cnt_clr = 1'b1;
      if (TIMER == 1) begin
        shift_dir = req;
        state_d   = ST_FIRED;
      end else begin
        state_d = ST_ARM;
        cnt_en  = 1'b1;
      end
    end
  end

  // Rotation equals a plain shift away from the ends; at an end without WRAP, hold.
  always_comb begin
    out_d = out_q;
    case (shift_dir)
      DIR_L: if (WRAP != 0 || !out_q[WIDTH-1]) out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      DIR_R: if (WRAP != 0 || !out_q[0])       out_d = {out_q[0], out_q[WIDTH-1:1]};
      default: ;
    endcase
    shifted_d = (out_d != out_q);

    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (out_q[i]) pos = PW'(i);
    end
  end

  assign out     = out_q;
  assign at_msb  = out_q[WIDTH-1];
  assign at_lsb  = out_q[0];
  assign shifted = shifted_q;

endmodule
